wb_ctrl: RTL and testbench

Writeback-port controller for the single-issue RV32 core. It owns the one register-file write port and drives the select input of the writeback mux (ALU / MEM / PC+4 / CSR). It sequences a single outstanding multi-cycle load and lets non-dependent ALU, PC+4 and CSR results retire while the load is in flight. It stalls decode on load-use hazards and aborts a load whose response never arrives.

---
 rtl/wb_pkg.sv | 21 ++
 rtl/wb_timeout_cnt.sv | 35 +++
 rtl/wb_ctrl.sv | 120 ++++++++++++
 tb/tb_wb_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared encodings for the writeback controller: mux select values and FSM states.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_CSR = 2'd3
  } wb_sel_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } wb_state_e;

  // Counter width that holds TIMEOUT-1 without wrapping (at least one bit).
  function automatic int cnt_width(input int timeout);
    return (timeout > 2) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Load watchdog: counts cycles spent waiting for a memory response and flags the
// final permitted cycle so the controller can abort the load.
module wb_timeout_cnt
  import wb_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CW      = cnt_width(TIMEOUT)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o,
  output logic          expire_o
);

  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt_o    = cnt_q;
  assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/wb_ctrl.sv
// Writeback-port controller: owns the register-file write port, sequences one
// outstanding load, and stalls decode on load-use hazards.
//
// state | meaning
// IDLE  | no load outstanding; every presented instruction is accepted
// WAIT  | one load in flight; non-conflicting results may still retire
module wb_ctrl
  import wb_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int XLEN_RD = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               io_ex_valid,
  input  logic [1:0]         io_ex_wb_sel,
  input  logic               io_ex_wen,
  input  logic [XLEN_RD-1:0] io_ex_rd,
  output logic               io_ex_ready,
  input  logic               io_mem_resp_valid,
  input  logic [XLEN_RD-1:0] io_id_rs1,
  input  logic [XLEN_RD-1:0] io_id_rs2,
  output logic               io_id_stall,
  output logic [1:0]         io_wb_sel,
  output logic               io_rf_wen,
  output logic [XLEN_RD-1:0] io_rf_waddr,
  output logic               io_load_pending,
  output logic               io_mem_timeout
);

  localparam int CW = cnt_width(TIMEOUT);

  wb_state_e          state_q, state_d;
  logic [XLEN_RD-1:0] pend_rd_q, pend_rd_d;
  logic               pend_wen_q, pend_wen_d;

  logic          in_wait, ex_mem, ex_waw, ex_retire, load_accept;
  logic          cnt_clr, cnt_expire;
  logic [CW-1:0] cnt;

  assign in_wait     = (state_q == WAIT);
  assign ex_mem      = (io_ex_wb_sel == WB_MEM);
  assign ex_waw      = io_ex_wen && (io_ex_rd == pend_rd_q);
  assign load_accept = !in_wait && io_ex_valid && ex_mem;
  // In WAIT an instruction retires only if it cannot collide with the pending load.
  assign ex_retire   = io_ex_valid && !ex_mem &&
                       (!in_wait || (!io_mem_resp_valid && !ex_waw));

  // Counter runs only while the load keeps waiting; it is zero on every WAIT entry.
  assign cnt_clr = !in_wait || io_mem_resp_valid || cnt_expire;

  wb_timeout_cnt #(.TIMEOUT(TIMEOUT), .CW(CW)) u_timeout (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_i    (cnt_clr),
    .en_i     (in_wait),
    .cnt_o    (cnt),
    .expire_o (cnt_expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pend_rd_q  <= '0;
      pend_wen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_rd_q  <= pend_rd_d;
      pend_wen_q <= pend_wen_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pend_rd_d  = pend_rd_q;
    pend_wen_d = pend_wen_q;
    unique case (state_q)
      IDLE: begin
        if (load_accept) begin
          state_d    = WAIT;
          pend_rd_d  = io_ex_rd;
          pend_wen_d = io_ex_wen;
        end
      end
      WAIT: begin
        if (io_mem_resp_valid || cnt_expire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    io_ex_ready     = 1'b1;
    io_wb_sel       = WB_ALU;
    io_rf_wen       = 1'b0;
    io_rf_waddr     = '0;
    io_load_pending = in_wait;
    io_mem_timeout  = 1'b0;
    if (in_wait && io_mem_resp_valid) begin
      io_ex_ready = 1'b0;
      io_wb_sel   = WB_MEM;
      io_rf_wen   = pend_wen_q && (pend_rd_q != '0);
      io_rf_waddr = pend_rd_q;
    end else begin
      if (in_wait) begin
        io_ex_ready    = !(io_ex_valid && (ex_mem || ex_waw));
        io_mem_timeout = cnt_expire;
      end
      if (ex_retire) begin
        io_wb_sel   = io_ex_wb_sel;
        io_rf_wen   = io_ex_wen && (io_ex_rd != '0);
        io_rf_waddr = io_ex_rd;
      end
    end
  end

  assign io_id_stall = in_wait && (pend_rd_q != '0) &&
                       ((io_id_rs1 == pend_rd_q) || (io_id_rs2 == pend_rd_q));

endmodule

// File: tb/tb_wb_ctrl.sv
// Directed bench for wb_ctrl with TIMEOUT=4: ALU retire, load sequencing,
// WAW blocking, load-use stall, timeout, and reset during a load.
module tb_wb_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       io_ex_valid;
  logic [1:0] io_ex_wb_sel;
  logic       io_ex_wen;
  logic [4:0] io_ex_rd;
  logic       io_ex_ready;
  logic       io_mem_resp_valid;
  logic [4:0] io_id_rs1, io_id_rs2;
  logic       io_id_stall;
  logic [1:0] io_wb_sel;
  logic       io_rf_wen;
  logic [4:0] io_rf_waddr;
  logic       io_load_pending;
  logic       io_mem_timeout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_ctrl #(.TIMEOUT(4), .XLEN_RD(5)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .io_ex_valid       (io_ex_valid),
    .io_ex_wb_sel      (io_ex_wb_sel),
    .io_ex_wen         (io_ex_wen),
    .io_ex_rd          (io_ex_rd),
    .io_ex_ready       (io_ex_ready),
    .io_mem_resp_valid (io_mem_resp_valid),
    .io_id_rs1         (io_id_rs1),
    .io_id_rs2         (io_id_rs2),
    .io_id_stall       (io_id_stall),
    .io_wb_sel         (io_wb_sel),
    .io_rf_wen         (io_rf_wen),
    .io_rf_waddr       (io_rf_waddr),
    .io_load_pending   (io_load_pending),
    .io_mem_timeout    (io_mem_timeout)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compares the whole output set: ready, wen, waddr, sel, pending, timeout, stall.
  task automatic chk_all(input string tag, input logic rdy, input logic wen,
                         input logic [4:0] wa, input logic [1:0] sel,
                         input logic pend, input logic tmo, input logic stl);
    chk({tag, ".ex_ready"},     8'(io_ex_ready),     8'(rdy));
    chk({tag, ".rf_wen"},       8'(io_rf_wen),       8'(wen));
    if (wen) chk({tag, ".rf_waddr"}, 8'(io_rf_waddr), 8'(wa));
    if (wen) chk({tag, ".wb_sel"},   8'(io_wb_sel),   8'(sel));
    chk({tag, ".load_pending"}, 8'(io_load_pending), 8'(pend));
    chk({tag, ".mem_timeout"},  8'(io_mem_timeout),  8'(tmo));
    chk({tag, ".id_stall"},     8'(io_id_stall),     8'(stl));
  endtask

  task automatic drive(input logic v, input logic [1:0] sel, input logic wen,
                       input logic [4:0] rd, input logic resp);
    io_ex_valid       = v;
    io_ex_wb_sel      = sel;
    io_ex_wen         = wen;
    io_ex_rd          = rd;
    io_mem_resp_valid = resp;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    io_id_rs1 = '0;
    io_id_rs2 = '0;
    drive(0, 2'd0, 0, 5'd0, 0);
    #1;
    chk_all("reset", 1, 0, 0, 0, 0, 0, 0);
    chk("reset.wb_sel",   8'(io_wb_sel),   8'd0);
    chk("reset.rf_waddr", 8'(io_rf_waddr), 8'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // IDLE retires
    drive(1, 2'd0, 1, 5'd5, 0); #1; chk_all("alu_rd5", 1, 1, 5, 0, 0, 0, 0);
    drive(1, 2'd0, 1, 5'd0, 0); #1; chk_all("alu_rd0", 1, 0, 0, 0, 0, 0, 0);
    drive(1, 2'd2, 1, 5'd6, 0); #1; chk_all("pc4_rd6", 1, 1, 6, 2, 0, 0, 0);
    drive(1, 2'd3, 0, 5'd6, 0); #1; chk_all("csr_nowen", 1, 0, 0, 0, 0, 0, 0);
    drive(0, 2'd0, 0, 5'd0, 1); #1; chk_all("spurious_resp", 1, 0, 0, 0, 0, 0, 0);

    // Load rd=7, response on 3rd WAIT cycle
    drive(1, 2'd1, 1, 5'd7, 0); #1; chk_all("ld7_issue", 1, 0, 0, 0, 0, 0, 0);
    tick(); drive(0, 2'd0, 0, 5'd0, 0); #1; chk_all("ld7_w1", 1, 0, 0, 0, 1, 0, 0);
    tick(); #1; chk_all("ld7_w2", 1, 0, 0, 0, 1, 0, 0);
    tick(); drive(0, 2'd0, 0, 5'd0, 1); #1; chk_all("ld7_resp", 0, 1, 7, 1, 1, 0, 0);
    tick(); drive(0, 2'd0, 0, 5'd0, 0); #1; chk_all("ld7_idle", 1, 0, 0, 0, 0, 0, 0);

    // Independent retire during WAIT, then WAW block
    drive(1, 2'd1, 1, 5'd7, 0); #1;
    tick(); drive(1, 2'd0, 1, 5'd9, 0); #1; chk_all("wait_alu9", 1, 1, 9, 0, 1, 0, 0);
    tick(); drive(1, 2'd0, 1, 5'd7, 0); #1; chk_all("waw_block", 0, 0, 0, 0, 1, 0, 0);
    tick(); drive(1, 2'd0, 1, 5'd7, 1); #1; chk_all("waw_resp", 0, 1, 7, 1, 1, 0, 0);
    tick(); drive(1, 2'd0, 1, 5'd7, 0); #1; chk_all("waw_retire", 1, 1, 7, 0, 0, 0, 0);
    tick(); drive(1, 2'd1, 0, 5'd2, 0); #1;
    tick(); drive(1, 2'd1, 1, 5'd8, 0); #1; chk_all("wait_mem_block", 0, 0, 0, 0, 1, 0, 0);
    tick(); drive(0, 2'd0, 0, 5'd0, 1); #1; chk_all("nowen_resp", 0, 0, 0, 0, 1, 0, 0);

    // Load-use stall on rs2
    tick(); io_id_rs2 = 5'd3; drive(1, 2'd1, 1, 5'd3, 0); #1;
    chk_all("st3_issue", 1, 0, 0, 0, 0, 0, 0);
    tick(); drive(0, 2'd0, 0, 5'd0, 0); #1; chk_all("st3_w1", 1, 0, 0, 0, 1, 0, 1);
    tick(); drive(0, 2'd0, 0, 5'd0, 1); #1; chk_all("st3_resp", 0, 1, 3, 1, 1, 0, 1);
    tick(); drive(0, 2'd0, 0, 5'd0, 0); #1; chk_all("st3_after", 1, 0, 0, 0, 0, 0, 0);

    // Load to x0 never stalls nor writes
    io_id_rs2 = 5'd0; io_id_rs1 = 5'd0; drive(1, 2'd1, 1, 5'd0, 0); #1;
    tick(); drive(0, 2'd0, 0, 5'd0, 0); #1; chk_all("x0_w1", 1, 0, 0, 0, 1, 0, 0);
    tick(); drive(0, 2'd0, 0, 5'd0, 1); #1; chk_all("x0_resp", 0, 0, 0, 0, 1, 0, 0);

    // Timeout on 4th WAIT cycle, with an ALU retire in that cycle
    tick(); drive(1, 2'd1, 1, 5'd4, 0); #1;
    tick(); drive(0, 2'd0, 0, 5'd0, 0); #1; chk_all("to_w1", 1, 0, 0, 0, 1, 0, 0);
    tick(); #1; chk_all("to_w2", 1, 0, 0, 0, 1, 0, 0);
    tick(); #1; chk_all("to_w3", 1, 0, 0, 0, 1, 0, 0);
    tick(); drive(1, 2'd0, 1, 5'd9, 0); #1; chk_all("to_w4", 1, 1, 9, 0, 1, 1, 0);
    tick(); drive(0, 2'd0, 0, 5'd0, 0); #1; chk_all("to_idle", 1, 0, 0, 0, 0, 0, 0);

    // Response on the timeout cycle wins
    drive(1, 2'd1, 1, 5'd4, 0); #1;
    tick(); drive(0, 2'd0, 0, 5'd0, 0); #1;
    tick(); #1;
    tick(); #1; chk_all("rt_w3", 1, 0, 0, 0, 1, 0, 0);
    tick(); drive(0, 2'd0, 0, 5'd0, 1); #1; chk_all("rt_resp", 0, 1, 4, 1, 1, 0, 0);
    tick(); drive(0, 2'd0, 0, 5'd0, 0); #1; chk_all("rt_idle", 1, 0, 0, 0, 0, 0, 0);

    // Reset during WAIT drops the load
    io_id_rs1 = 5'd8; drive(1, 2'd1, 1, 5'd8, 0); #1;
    tick(); drive(0, 2'd0, 0, 5'd0, 0); #1; chk_all("rs_w1", 1, 0, 0, 0, 1, 0, 1);
    reset_n = 1'b0; #1; chk_all("rs_async", 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk); reset_n = 1'b1;
    tick(); drive(0, 2'd0, 0, 5'd0, 1); #1; chk_all("rs_late_resp", 1, 0, 0, 0, 0, 0, 0);
    tick(); drive(0, 2'd0, 0, 5'd0, 0); #1; chk_all("rs_final", 1, 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
